// File: rtl/friscv_div_ctrl.sv
// ----------------------------------------------------------------------------
// friscv_div_ctrl
//
// Sequencer between the M-extension execute stage and the shared iterative
// integer divider. It accepts DIV/DIVU/REM/REMU requests and resolves the
// RISC-V corner cases locally:
//   - divide-by-zero (quotient all ones, remainder = dividend)
//   - signed overflow (MIN / -1: quotient = dividend, remainder = 0)
// A one-entry cache holds the last divider result pair (quotient and
// remainder), so a DIV/REM pair on the same operands costs one divider run.
//
// Ports
//   aclk, aresetn        clock, synchronous active-low reset
//   i_valid/i_ready      request handshake
//   i_funct3             4=DIV 5=DIVU 6=REM 7=REMU (funct3[2]=0 -> DIVU)
//   i_rs1, i_rs2, i_rd   dividend, divisor, destination index
//   o_valid/o_ready      result handshake
//   o_rd, o_result       destination index and quotient/remainder
//   o_zero_div           result produced by the divide-by-zero rule
//   o_cache_hit          result served from the cache
//   busy                 controller not in IDLE
//   div_valid/div_ready  divider request handshake
//   div_signed, div_divd, div_divs  divider request payload
//   div_o_valid/div_o_ready         divider result handshake
//   div_quot, div_rem    divider result payload
// ----------------------------------------------------------------------------
module friscv_div_ctrl #(
    parameter int XLEN = 32,
    parameter int RDW  = 5
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic            i_valid,
    output logic            i_ready,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [RDW-1:0]  i_rd,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [RDW-1:0]  o_rd,
    output logic [XLEN-1:0] o_result,
    output logic            o_zero_div,
    output logic            o_cache_hit,
    output logic            busy,
    output logic            div_valid,
    input  logic            div_ready,
    output logic            div_signed,
    output logic [XLEN-1:0] div_divd,
    output logic [XLEN-1:0] div_divs,
    input  logic            div_o_valid,
    output logic            div_o_ready,
    input  logic [XLEN-1:0] div_quot,
    input  logic [XLEN-1:0] div_rem
);

    // state | meaning
    // IDLE  | ready for a request, corner cases and cache resolved on accept
    // ISSUE | presenting the registered operands to the divider
    // WAIT  | waiting for the divider result
    // RESP  | holding the result until the consumer takes it
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};

    state_t state;
    state_t state_nxt;

    // Registered request
    logic [XLEN-1:0] req_rs1;
    logic [XLEN-1:0] req_rs2;
    logic            req_sgn;
    logic            req_rem;

    // Result cache
    logic            cache_valid;
    logic [XLEN-1:0] cache_rs1;
    logic [XLEN-1:0] cache_rs2;
    logic            cache_sgn;
    logic [XLEN-1:0] cache_quot;
    logic [XLEN-1:0] cache_rem;

    // Request decode and classification, evaluated on the live inputs so
    // the fast paths can answer one cycle after the accept edge.
    logic accept;
    logic dec_sgn;
    logic dec_rem;
    logic is_zero;
    logic is_ovf;
    logic is_hit;

    // funct3[2]=0 collapses to DIVU: unsigned, quotient.
    assign dec_sgn = i_funct3[2] & ~i_funct3[0];
    assign dec_rem = i_funct3[2] &  i_funct3[1];

    assign is_zero = (i_rs2 == ZERO);
    assign is_ovf  = dec_sgn & (i_rs1 == INT_MIN) & (i_rs2 == ALL_ONES);
    assign is_hit  = cache_valid & (i_rs1 == cache_rs1) &
                     (i_rs2 == cache_rs2) & (dec_sgn == cache_sgn);

    assign accept  = i_valid & i_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        i_ready     = 1'b0;
        o_valid     = 1'b0;
        div_valid   = 1'b0;
        div_o_ready = 1'b0;
        busy        = 1'b1;

        case (state)
            IDLE: begin
                // Held low while reset is asserted so every output reads 0.
                i_ready = aresetn;
                busy    = 1'b0;
                if (accept) begin
                    if (is_zero || is_ovf || is_hit) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                div_valid = 1'b1;
                if (div_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                div_o_ready = 1'b1;
                if (div_o_valid) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                o_valid = 1'b1;
                if (o_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request, result and cache registers
    // ------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            req_rs1     <= ZERO;
            req_rs2     <= ZERO;
            req_sgn     <= 1'b0;
            req_rem     <= 1'b0;
            o_rd        <= '0;
            o_result    <= ZERO;
            o_zero_div  <= 1'b0;
            o_cache_hit <= 1'b0;
            cache_valid <= 1'b0;
            cache_rs1   <= ZERO;
            cache_rs2   <= ZERO;
            cache_sgn   <= 1'b0;
            cache_quot  <= ZERO;
            cache_rem   <= ZERO;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_rs1 <= i_rs1;
                        req_rs2 <= i_rs2;
                        req_sgn <= dec_sgn;
                        req_rem <= dec_rem;
                        o_rd    <= i_rd;
                        if (is_zero) begin
                            o_result   <= dec_rem ? i_rs1 : ALL_ONES;
                            o_zero_div <= 1'b1;
                        end else if (is_ovf) begin
                            o_result <= dec_rem ? ZERO : i_rs1;
                        end else if (is_hit) begin
                            o_result    <= dec_rem ? cache_rem : cache_quot;
                            o_cache_hit <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (div_o_valid) begin
                        o_result    <= req_rem ? div_rem : div_quot;
                        // Only divider results refill the cache; corner-case
                        // answers never displace a useful entry.
                        cache_valid <= 1'b1;
                        cache_rs1   <= req_rs1;
                        cache_rs2   <= req_rs2;
                        cache_sgn   <= req_sgn;
                        cache_quot  <= div_quot;
                        cache_rem   <= div_rem;
                    end
                end
                RESP: begin
                    if (o_ready) begin
                        o_zero_div  <= 1'b0;
                        o_cache_hit <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The divider sees the registered request, so its payload is stable
    // for the whole time div_valid waits on div_ready.
    assign div_divd   = req_rs1;
    assign div_divs   = req_rs2;
    assign div_signed = req_sgn;

endmodule

// File: tb/tb_friscv_div_ctrl.sv
// ----------------------------------------------------------------------------
// tb_friscv_div_ctrl
//
// Directed bench for friscv_div_ctrl. A small behavioural divider answers
// requests a few cycles after its handshake. Inputs change #1 after the
// rising edge; outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_friscv_div_ctrl;

    localparam int XLEN    = 32;
    localparam int RDW     = 5;
    localparam int DIV_LAT = 3;
    localparam int TMO     = 60;

    logic            aclk;
    logic            aresetn;
    logic            i_valid;
    logic            i_ready;
    logic [2:0]      i_funct3;
    logic [XLEN-1:0] i_rs1;
    logic [XLEN-1:0] i_rs2;
    logic [RDW-1:0]  i_rd;
    logic            o_valid;
    logic            o_ready;
    logic [RDW-1:0]  o_rd;
    logic [XLEN-1:0] o_result;
    logic            o_zero_div;
    logic            o_cache_hit;
    logic            busy;
    logic            div_valid;
    logic            div_ready;
    logic            div_signed;
    logic [XLEN-1:0] div_divd;
    logic [XLEN-1:0] div_divs;
    logic            div_o_valid;
    logic            div_o_ready;
    logic [XLEN-1:0] div_quot;
    logic [XLEN-1:0] div_rem;

    int errors = 0;
    int checks = 0;
    int div_hs_cnt = 0;
    int o_hs_cnt = 0;

    // Results of the last do_req call
    logic [XLEN-1:0] res;
    logic [RDW-1:0]  rdo;
    logic            zd;
    logic            hit;
    logic            sgn;
    int              lat;
    int              lat_div;
    bit              saw_div;
    bit              excl;
    bit              tmo;

    friscv_div_ctrl #(.XLEN(XLEN), .RDW(RDW)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .i_funct3    (i_funct3),
        .i_rs1       (i_rs1),
        .i_rs2       (i_rs2),
        .i_rd        (i_rd),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_rd        (o_rd),
        .o_result    (o_result),
        .o_zero_div  (o_zero_div),
        .o_cache_hit (o_cache_hit),
        .busy        (busy),
        .div_valid   (div_valid),
        .div_ready   (div_ready),
        .div_signed  (div_signed),
        .div_divd    (div_divd),
        .div_divs    (div_divs),
        .div_o_valid (div_o_valid),
        .div_o_ready (div_o_ready),
        .div_quot    (div_quot),
        .div_rem     (div_rem)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (aresetn && o_valid && o_ready) o_hs_cnt++;
    end

    // Behavioural divider: samples the request on the falling edge before
    // the handshake edge, answers DIV_LAT cycles later, drops on reset.
    initial begin
        logic [XLEN-1:0] q;
        logic [XLEN-1:0] r;
        bit abort;
        int n;
        div_o_valid = 1'b0;
        div_quot    = '0;
        div_rem     = '0;
        forever begin
            @(negedge aclk);
            if (aresetn && div_valid && div_ready) begin
                if (div_signed) begin
                    q = $signed(div_divd) / $signed(div_divs);
                    r = $signed(div_divd) % $signed(div_divs);
                end else begin
                    q = div_divd / div_divs;
                    r = div_divd % div_divs;
                end
                div_hs_cnt++;
                abort = 1'b0;
                @(posedge aclk);
                for (int i = 0; i < DIV_LAT; i++) begin
                    @(posedge aclk);
                    if (!aresetn) begin
                        abort = 1'b1;
                        break;
                    end
                end
                if (!abort) begin
                    #1;
                    div_quot    = q;
                    div_rem     = r;
                    div_o_valid = 1'b1;
                    n = 0;
                    forever begin
                        @(negedge aclk);
                        if (!aresetn) break;
                        if (div_o_ready) begin
                            @(posedge aclk);
                            break;
                        end
                        n++;
                        if (n > TMO) break;
                    end
                    #1;
                    div_o_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // One request with o_ready held high. lat counts falling edges after
    // the accept edge until o_valid; lat_div counts them from the falling
    // edge where the divider result was offered to the one showing o_valid.
    task automatic do_req(input logic [2:0] f3, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [RDW-1:0] rd);
        int n;
        int k_div;
        res = '0; rdo = '0; zd = 1'b0; hit = 1'b0; sgn = 1'b0;
        lat = 0; lat_div = -1; saw_div = 1'b0; excl = 1'b1; tmo = 1'b0;
        k_div = -1;
        @(posedge aclk); #1;
        i_valid = 1'b1; i_funct3 = f3; i_rs1 = a; i_rs2 = b; i_rd = rd;
        n = 0;
        @(negedge aclk);
        while (!i_ready && n < TMO) begin
            @(negedge aclk);
            n++;
        end
        if (!i_ready) begin
            tmo = 1'b1;
        end else begin
            @(posedge aclk); #1;
            i_valid = 1'b0;
            n = 0;
            forever begin
                @(negedge aclk);
                n++;
                if (int'(i_ready) + int'(div_valid) + int'(o_valid) > 1) excl = 1'b0;
                if (div_valid) begin
                    saw_div = 1'b1;
                    sgn = div_signed;
                end
                if (o_valid) begin
                    lat = n; res = o_result; rdo = o_rd;
                    zd = o_zero_div; hit = o_cache_hit;
                    break;
                end
                if (div_o_valid && div_o_ready) k_div = n;
                if (n >= TMO) begin
                    tmo = 1'b1;
                    break;
                end
            end
            if (k_div >= 0) lat_div = lat - k_div;
            @(posedge aclk); #1;
        end
        i_valid = 1'b0;
        checks++;
        if (tmo) begin errors++; $display("FAIL req_timeout f3=%0d rs1=%h rs2=%h got=no response required=response", f3, a, b); end
    endtask

    task automatic test_reset();
        aresetn = 1'b0; i_valid = 1'b0; i_funct3 = 3'd0; i_rs1 = '0; i_rs2 = '0;
        i_rd = '0; o_ready = 1'b1; div_ready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL rst_i_ready got=%b required=0", i_ready); end
        checks++; if ({o_valid, busy, div_valid, div_o_ready, o_zero_div, o_cache_hit} !== 6'b0) begin errors++; $display("FAIL rst_ctrl got=%b required=000000", {o_valid, busy, div_valid, div_o_ready, o_zero_div, o_cache_hit}); end
        checks++; if ({o_result, o_rd, div_divd, div_divs, div_signed} !== '0) begin errors++; $display("FAIL rst_data got=%h/%h/%h/%h required=0", o_result, o_rd, div_divd, div_divs); end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        checks++; if (i_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_release i_ready=%b busy=%b required=1/0", i_ready, busy); end
    endtask

    task automatic test_cache_unsigned();
        do_req(3'd5, 32'd100, 32'd7, 5'd3);
        checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_result got=%h required=%h", res, 32'd14); end
        checks++; if (rdo !== 5'd3) begin errors++; $display("FAIL divu_rd got=%0d required=3", rdo); end
        checks++; if (hit !== 1'b0 || saw_div !== 1'b1 || sgn !== 1'b0) begin errors++; $display("FAIL divu_path hit=%b div=%b sgn=%b required=0/1/0", hit, saw_div, sgn); end
        checks++; if (lat_div != 1) begin errors++; $display("FAIL divu_latency got=%0d required=1", lat_div); end
        checks++; if (!excl) begin errors++; $display("FAIL divu_exclusive got=overlap required=exclusive"); end
        do_req(3'd7, 32'd100, 32'd7, 5'd4);
        checks++; if (res !== 32'd2) begin errors++; $display("FAIL remu_hit_result got=%h required=%h", res, 32'd2); end
        checks++; if (hit !== 1'b1 || saw_div !== 1'b0 || rdo !== 5'd4) begin errors++; $display("FAIL remu_hit_path hit=%b div=%b rd=%0d required=1/0/4", hit, saw_div, rdo); end
        checks++; if (lat != 1) begin errors++; $display("FAIL remu_hit_latency got=%0d required=1", lat); end
        @(negedge aclk);
        checks++; if (o_cache_hit !== 1'b0 || o_valid !== 1'b0) begin errors++; $display("FAIL hit_clear hit=%b o_valid=%b required=0/0", o_cache_hit, o_valid); end
    endtask

    task automatic test_signed();
        do_req(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10);
        checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_result got=%h required=fffffffd", res); end
        checks++; if (hit !== 1'b0 || saw_div !== 1'b1 || sgn !== 1'b1) begin errors++; $display("FAIL div_neg_path hit=%b div=%b sgn=%b required=0/1/1", hit, saw_div, sgn); end
        do_req(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11);
        checks++; if (res !== 32'hFFFF_FFFF || hit !== 1'b1 || saw_div !== 1'b0) begin errors++; $display("FAIL rem_neg_hit got=%h hit=%b div=%b required=ffffffff/1/0", res, hit, saw_div); end
    endtask

    task automatic test_zero_div();
        do_req(3'd4, 32'd5, 32'd0, 5'd12);
        checks++; if (res !== 32'hFFFF_FFFF || zd !== 1'b1) begin errors++; $display("FAIL div_zero got=%h zd=%b required=ffffffff/1", res, zd); end
        checks++; if (saw_div !== 1'b0 || hit !== 1'b0 || lat != 1) begin errors++; $display("FAIL div_zero_path div=%b hit=%b lat=%0d required=0/0/1", saw_div, hit, lat); end
        do_req(3'd6, 32'd5, 32'd0, 5'd13);
        checks++; if (res !== 32'd5 || zd !== 1'b1 || saw_div !== 1'b0 || rdo !== 5'd13) begin errors++; $display("FAIL rem_zero got=%h zd=%b div=%b rd=%0d required=5/1/0/13", res, zd, saw_div, rdo); end
        @(negedge aclk);
        checks++; if (o_zero_div !== 1'b0) begin errors++; $display("FAIL zero_clear got=%b required=0", o_zero_div); end
        do_req(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd14);
        checks++; if (res !== 32'hFFFF_FFFD || hit !== 1'b1 || saw_div !== 1'b0) begin errors++; $display("FAIL cache_kept got=%h hit=%b div=%b required=fffffffd/1/0", res, hit, saw_div); end
    endtask

    task automatic test_overflow();
        do_req(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
        checks++; if (res !== 32'h8000_0000 || zd !== 1'b0 || hit !== 1'b0) begin errors++; $display("FAIL ovf_div got=%h zd=%b hit=%b required=80000000/0/0", res, zd, hit); end
        checks++; if (saw_div !== 1'b0 || lat != 1) begin errors++; $display("FAIL ovf_div_path div=%b lat=%0d required=0/1", saw_div, lat); end
        do_req(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
        checks++; if (res !== 32'd0 || saw_div !== 1'b0) begin errors++; $display("FAIL ovf_rem got=%h div=%b required=0/0", res, saw_div); end
        do_req(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17);
        checks++; if (res !== 32'd0 || saw_div !== 1'b1 || hit !== 1'b0 || sgn !== 1'b0) begin errors++; $display("FAIL ovf_divu got=%h div=%b hit=%b sgn=%b required=0/1/0/0", res, saw_div, hit, sgn); end
        do_req(3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18);
        checks++; if (res !== 32'h8000_0000 || hit !== 1'b1) begin errors++; $display("FAIL ovf_remu_hit got=%h hit=%b required=80000000/1", res, hit); end
    endtask

    task automatic test_illegal_funct3();
        do_req(3'd2, 32'd100, 32'd7, 5'd19);
        checks++; if (res !== 32'd14 || saw_div !== 1'b1 || sgn !== 1'b0) begin errors++; $display("FAIL illegal_as_divu got=%h div=%b sgn=%b required=0000000e/1/0", res, saw_div, sgn); end
        do_req(3'd6, 32'd100, 32'd7, 5'd20);
        checks++; if (res !== 32'd2 || hit !== 1'b0 || sgn !== 1'b1) begin errors++; $display("FAIL sign_miss got=%h hit=%b sgn=%b required=2/0/1", res, hit, sgn); end
    endtask

    task automatic test_back_pressure();
        int hs0;
        int o0;
        int n;
        bit ok;
        hs0 = div_hs_cnt;
        o0  = o_hs_cnt;
        div_ready = 1'b0;
        @(posedge aclk); #1;
        i_valid = 1'b1; i_funct3 = 3'd5; i_rs1 = 32'd1000; i_rs2 = 32'd10; i_rd = 5'd9;
        @(negedge aclk);
        checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL bp_idle got=%b required=1", i_ready); end
        @(posedge aclk); #1;
        i_valid = 1'b0; i_rs1 = '1; i_rs2 = '1; i_rd = '1;
        ok = 1'b1;
        repeat (5) begin
            @(negedge aclk);
            if (!(div_valid && div_divd == 32'd1000 && div_divs == 32'd10 && !i_ready && !o_valid)) ok = 1'b0;
        end
        checks++; if (!ok) begin errors++; $display("FAIL bp_issue_hold got=valid%b divd=%h divs=%h required=1/3e8/a", div_valid, div_divd, div_divs); end
        @(posedge aclk); #1;
        div_ready = 1'b1; o_ready = 1'b0;
        n = 0;
        @(negedge aclk);
        while (!o_valid && n < TMO) begin
            @(negedge aclk);
            n++;
        end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_resp got=%b required=1", o_valid); end
        ok = 1'b1;
        repeat (4) begin
            @(negedge aclk);
            if (!(o_valid && o_result == 32'd100 && o_rd == 5'd9 && !i_ready && !div_valid)) ok = 1'b0;
        end
        checks++; if (!ok) begin errors++; $display("FAIL bp_resp_hold got=valid%b res=%h rd=%0d required=1/64/9", o_valid, o_result, o_rd); end
        @(posedge aclk); #1;
        o_ready = 1'b1;
        @(posedge aclk); #1;
        @(negedge aclk);
        checks++; if (o_valid !== 1'b0 || i_ready !== 1'b1) begin errors++; $display("FAIL bp_done o_valid=%b i_ready=%b required=0/1", o_valid, i_ready); end
        checks++; if (div_hs_cnt - hs0 != 1 || o_hs_cnt - o0 != 1) begin errors++; $display("FAIL bp_handshakes div=%0d out=%0d required=1/1", div_hs_cnt - hs0, o_hs_cnt - o0); end
    endtask

    task automatic test_reset_mid();
        int n;
        int hs0;
        @(posedge aclk); #1;
        i_valid = 1'b1; i_funct3 = 3'd5; i_rs1 = 32'd50; i_rs2 = 32'd8; i_rd = 5'd7;
        @(negedge aclk);
        @(posedge aclk); #1;
        i_valid = 1'b0;
        n = 0;
        @(negedge aclk);
        while (!div_o_ready && n < TMO) begin
            @(negedge aclk);
            n++;
        end
        checks++; if (div_o_ready !== 1'b1) begin errors++; $display("FAIL rm_wait got=%b required=1", div_o_ready); end
        @(posedge aclk); #1;
        aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        checks++; if (busy !== 1'b0 || o_valid !== 1'b0 || i_ready !== 1'b1 || div_o_ready !== 1'b0) begin errors++; $display("FAIL rm_idle busy=%b o_valid=%b i_ready=%b div_o_ready=%b required=0/0/1/0", busy, o_valid, i_ready, div_o_ready); end
        hs0 = div_hs_cnt;
        do_req(3'd5, 32'd50, 32'd8, 5'd7);
        checks++; if (res !== 32'd6 || hit !== 1'b0 || saw_div !== 1'b1 || div_hs_cnt - hs0 != 1) begin errors++; $display("FAIL rm_reissue got=%h hit=%b div=%b hs=%0d required=6/0/1/1", res, hit, saw_div, div_hs_cnt - hs0); end
        do_req(3'd7, 32'd1000, 32'd10, 5'd8);
        checks++; if (res !== 32'd0 || hit !== 1'b0 || saw_div !== 1'b1) begin errors++; $display("FAIL rm_cache_cleared got=%h hit=%b div=%b required=0/0/1", res, hit, saw_div); end
    endtask

    initial begin
        test_reset();
        test_cache_unsigned();
        test_signed();
        test_zero_div();
        test_overflow();
        test_illegal_funct3();
        test_back_pressure();
        test_reset_mid();
        repeat (2) @(posedge aclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/friscv_div_ctrl.md
Name: friscv_div_ctrl

Overview:
- Sequencer between the M-extension decode/execute stage and the shared iterative integer divider.
- Accepts DIV/DIVU/REM/REMU requests and applies RISC-V corner-case semantics locally: divide-by-zero and signed overflow.
- Keeps a one-entry result cache so a DIV followed by a REM on the same operands (or the reverse) completes without re-running the divider.
- Drives the divider through its valid/ready handshakes and returns one result per request with back-pressure.

Parameters:
- XLEN, 32, operand/result width; must match the divider WIDTH.
- RDW, 5, destination register index width.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- i_valid  in  1  request valid
- i_ready  out  1  request accepted when i_valid & i_ready
- i_funct3  in  3  4=DIV, 5=DIVU, 6=REM, 7=REMU; others illegal
- i_rs1  in  XLEN  dividend
- i_rs2  in  XLEN  divisor
- i_rd  in  RDW  destination index, returned unchanged
- o_valid  out  1  result valid
- o_ready  in  1  result consumed when o_valid & o_ready
- o_rd  out  RDW  destination index
- o_result  out  XLEN  quotient or remainder
- o_zero_div  out  1  result came from divide-by-zero
- o_cache_hit  out  1  result served from cache, for performance counting
- busy  out  1  high in any state other than IDLE
- div_valid  out  1  divider request
- div_ready  in  1  divider accept
- div_signed  out  1  signed division
- div_divd  out  XLEN  divider dividend
- div_divs  out  XLEN  divider divisor
- div_o_valid  in  1  divider result valid
- div_o_ready  out  1  divider result accept
- div_quot  in  XLEN  divider quotient
- div_rem  in  XLEN  divider remainder

Behaviour:
- Reset, sampled on the aclk edge while aresetn=0:
  - all outputs 0; state=IDLE; cache_valid=0; cached operands and results 0.
  - Reset mid-operation abandons the in-flight request. The divider is expected to be reset by the same reset.
- Decode:
  - sgn = ~funct3[0]; want_rem = funct3[1].
  - funct3[2]=0 is treated as DIVU; no error is flagged.
- State IDLE:
  - i_ready=1. All other handshake outputs are 0.
  - On accept, register rs1, rs2, sgn, want_rem and rd. Classify in priority order:
    1. rs2==0: quot = all ones, rem = rs1, zero_div=1. Go to RESP. Cache is not updated.
    2. sgn & rs1==1<<(XLEN-1) & rs2==all ones (signed overflow): quot = rs1, rem = 0. Go to RESP. Cache is not updated.
    3. Cache hit, i.e. cache_valid and rs1, rs2, sgn all equal the cached values: select cached quot or rem, o_cache_hit=1. Go to RESP.
    4. Otherwise go to ISSUE.
- State ISSUE:
  - div_valid=1 with div_divd, div_divs, div_signed driven from registers, stable while waiting.
  - On div_valid & div_ready, go to WAIT.
- State WAIT:
  - div_o_ready=1.
  - On div_o_valid: capture div_quot and div_rem. Set cache_valid=1 and load the cache with rs1, rs2, sgn and both results. Go to RESP.
- State RESP:
  - o_valid=1. o_result and o_rd are registered and stable until o_valid & o_ready.
  - On handshake, go to IDLE and clear o_zero_div and o_cache_hit.
- Latency, from accept edge T:
  - zero, overflow or hit: o_valid at T+1.
  - divider path: o_valid one cycle after div_o_valid is sampled.
  - Back-to-back throughput: one request per 2 cycles minimum, because RESP returns to IDLE.
- o_ready low: the block holds in RESP indefinitely, output stable, i_ready=0.
- Cache:
  - Single entry.
  - Overwritten only by divider results.
  - Never invalidated except by reset.
- i_ready, div_valid and o_valid are never high in the same cycle.

Test Plan:
- DIVU 100/7, then REMU 100/7 same operands -> 14 from the divider path; then 2 with o_cache_hit=1, o_valid 1 cycle after accept, div_valid never asserted for the second request.
- DIV -7/2 (0xFFFFFFF9, 2), then REM -7/2 -> 0xFFFFFFFD via the divider; then 0xFFFFFFFF from the cache.
- DIV 5/0 and REM 5/0 -> 0xFFFFFFFF and 5 respectively; o_zero_div=1; no div_valid; cache still holds the prior entry.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; DIVU same operands -> 0 via the divider (not the overflow path).
- Back-pressure: hold div_ready=0 for 5 cycles, then o_ready=0 for 4 cycles -> div_divd/div_divs and o_result/o_rd stable throughout; exactly one div_valid & div_ready handshake and one o_valid & o_ready handshake.
- Assert aresetn=0 for 1 cycle while in WAIT -> next cycle IDLE, o_valid=0, i_ready=1; repeating the last operands misses the cache and issues to the divider.
